// File: rtl/ps2_scancode_decoder.sv
// -----------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Collapses a raw PS/2 Set-2 scancode byte stream into single key events.
// E0 (extended), F0 (break) and the eight-byte E1 Pause sequence are folded
// into one {code, extended, release} event. Shift/Ctrl/Alt state is tracked
// from left/right latches, and device response bytes (FA, AA, FC, FE, EE, 00,
// FF) are split out of the key stream.
//
// Optional build macro: PS2_DECODE_TYPEMATIC_FILTER_EN
//   When defined, a 512-entry pressed bitmap indexed by {ext, code}
//   suppresses typematic repeat makes of keys already held down.
//
// Parameters
//   PAUSE_CODE      code reported (ext=1) for a complete Pause sequence
//   DROP_FAKE_SHIFT 1: E0 12 / E0 59 (make or break) produce no event
//
// Ports
//   main_clk, reset_n           clock, async active-low reset
//   byte_in/byte_valid/byte_ready, byte_parity_err
//                               input byte stream from the PS/2 controller
//   key_code/key_extended/key_release/key_valid/key_ready
//                               key event output, held until accepted
//   mod_shift/mod_ctrl/mod_alt  live modifier state
//   resp_valid/resp_byte        one-cycle pulse on a device response byte
//   seq_error                   one-cycle pulse on parity error / bad sequence
// -----------------------------------------------------------------------------
module ps2_scancode_decoder #(
  parameter logic [7:0] PAUSE_CODE      = 8'h77,
  parameter bit         DROP_FAKE_SHIFT = 1'b1
) (
  input  logic       main_clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_parity_err,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       resp_valid,
  output logic [7:0] resp_byte,
  output logic       seq_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] pidx_q, pidx_d;

  logic [7:0] code_q;
  logic       ext_q, rel_q, kvalid_q;
  logic       resp_valid_q, seq_err_q;
  logic [7:0] resp_byte_q;

  logic lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q;

  // Decoded event for the byte being accepted this cycle
  logic       accept;
  logic       ev_fire, ev_ext, ev_rel, ev_pause;
  logic [7:0] ev_code;
  logic       resp_fire, err_fire;
  logic       fake_shift, ev_suppress, ev_emit;

  function automatic logic is_resp(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hFC, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_resp = 1'b1;
      default:                                          is_resp = 1'b0;
    endcase
  endfunction

  // Expected bytes following the leading E1 of the Pause sequence
  function automatic logic [7:0] pause_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    pause_rom = 8'h14;
      3'd1:    pause_rom = 8'h77;
      3'd2:    pause_rom = 8'hE1;
      3'd3:    pause_rom = 8'hF0;
      3'd4:    pause_rom = 8'h14;
      3'd5:    pause_rom = 8'hF0;
      3'd6:    pause_rom = 8'h77;
      default: pause_rom = 8'h00;
    endcase
  endfunction

  // A stalled event blocks the byte path; a simultaneous key_ready lets the
  // event register reload in the same cycle.
  assign byte_ready = !kvalid_q || key_ready;
  assign accept     = byte_valid && byte_ready;

  // ---------------------------------------------------------------------------
  // Prefix FSM: next state and event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pidx_d    = pidx_q;
    ev_fire   = 1'b0;
    ev_code   = byte_in;
    ev_ext    = 1'b0;
    ev_rel    = 1'b0;
    ev_pause  = 1'b0;
    resp_fire = 1'b0;
    err_fire  = 1'b0;
    if (accept) begin
      if (byte_parity_err) begin
        // Corrupt byte: discard and resynchronise from any state
        err_fire = 1'b1;
        state_d  = S_IDLE;
        pidx_d   = 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (byte_in == 8'hE0)      state_d = S_E0;
            else if (byte_in == 8'hF0) state_d = S_F0;
            else if (byte_in == 8'hE1) begin
              state_d = S_PAUSE;
              pidx_d  = 3'd0;
            end
            else if (is_resp(byte_in)) resp_fire = 1'b1;
            else                       ev_fire   = 1'b1;
          end
          S_E0: begin
            if (byte_in == 8'hF0) state_d = S_E0F0;
            else begin
              state_d = S_IDLE;
              if (byte_in == 8'hE0 || byte_in == 8'hE1 || is_resp(byte_in)) begin
                err_fire = 1'b1;
              end else begin
                ev_fire = 1'b1;
                ev_ext  = 1'b1;
              end
            end
          end
          S_F0: begin
            ev_fire = 1'b1;
            ev_rel  = 1'b1;
            state_d = S_IDLE;
          end
          S_E0F0: begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
            state_d = S_IDLE;
          end
          S_PAUSE: begin
            if (byte_in != pause_rom(pidx_q)) begin
              err_fire = 1'b1;
              state_d  = S_IDLE;
              pidx_d   = 3'd0;
            end else if (pidx_q == 3'd6) begin
              ev_fire  = 1'b1;
              ev_pause = 1'b1;
              ev_code  = PAUSE_CODE;
              ev_ext   = 1'b1;
              state_d  = S_IDLE;
              pidx_d   = 3'd0;
            end else begin
              pidx_d = pidx_q + 3'd1;
            end
          end
          default: begin
            state_d = S_IDLE;
            pidx_d  = 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pidx_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
    end
  end

  // E0 12 / E0 59 are the fake shifts some keyboards wrap around extended keys
  assign fake_shift = ev_ext && !ev_pause && (ev_code == 8'h12 || ev_code == 8'h59);

  // ---------------------------------------------------------------------------
  // Typematic repeat filter
  // ---------------------------------------------------------------------------
`ifdef PS2_DECODE_TYPEMATIC_FILTER_EN
  logic [511:0] pressed_q;
  logic [8:0]   pidx_bit;
  logic         track;

  assign pidx_bit = {ev_ext, ev_code};
  // Pause has no break code, so it is never marked pressed
  assign track    = ev_fire && !ev_pause && !(fake_shift && DROP_FAKE_SHIFT);
  assign ev_suppress = track && !ev_rel && pressed_q[pidx_bit];

  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed_q <= '0;
    end else if (err_fire) begin
      pressed_q <= '0;
    end else if (track) begin
      pressed_q[pidx_bit] <= !ev_rel;
    end
  end
`else
  assign ev_suppress = 1'b0;
`endif

  assign ev_emit = ev_fire && !(fake_shift && DROP_FAKE_SHIFT) && !ev_suppress;

  // ---------------------------------------------------------------------------
  // Event register
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      kvalid_q <= 1'b0;
      code_q   <= 8'h00;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
    end else if (ev_emit) begin
      kvalid_q <= 1'b1;
      code_q   <= ev_code;
      ext_q    <= ev_ext;
      rel_q    <= ev_rel;
    end else if (key_ready) begin
      kvalid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Modifier latches. Extended 12/59 never match the non-extended shift
  // codes, and Pause is excluded explicitly, so neither touches modifiers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      lctrl_q  <= 1'b0;
      rctrl_q  <= 1'b0;
      lalt_q   <= 1'b0;
      ralt_q   <= 1'b0;
    end else if (ev_fire && !ev_pause) begin
      if (!ev_ext && ev_code == 8'h12) lshift_q <= !ev_rel;
      if (!ev_ext && ev_code == 8'h59) rshift_q <= !ev_rel;
      if (!ev_ext && ev_code == 8'h14) lctrl_q  <= !ev_rel;
      if ( ev_ext && ev_code == 8'h14) rctrl_q  <= !ev_rel;
      if (!ev_ext && ev_code == 8'h11) lalt_q   <= !ev_rel;
      if ( ev_ext && ev_code == 8'h11) ralt_q   <= !ev_rel;
    end
  end

  // ---------------------------------------------------------------------------
  // Response and error pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge main_clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_byte_q  <= 8'h00;
      seq_err_q    <= 1'b0;
    end else begin
      resp_valid_q <= resp_fire;
      seq_err_q    <= err_fire;
      if (resp_fire) resp_byte_q <= byte_in;
    end
  end

  assign key_valid    = kvalid_q;
  assign key_code     = code_q;
  assign key_extended = ext_q;
  assign key_release  = rel_q;
  assign mod_shift    = lshift_q | rshift_q;
  assign mod_ctrl     = lctrl_q  | rctrl_q;
  assign mod_alt      = lalt_q   | ralt_q;
  assign resp_valid   = resp_valid_q;
  assign resp_byte    = resp_byte_q;
  assign seq_error    = seq_err_q;

endmodule
